ysyx_lsu_ctrl: RTL



---
 rtl/ysyx_lsu_pkg.sv | 39 +++
 rtl/ysyx_lsu_align.sv | 57 +++++
 rtl/ysyx_lsu_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ysyx_lsu_pkg.sv
// Shared types and constants for the LSU controller: FSM states, size codes,
// strobe masks and the latched request record.
package ysyx_lsu_pkg;
  localparam int YSYX_W_WIDTH = 32;
  localparam int NUM_LANES    = YSYX_W_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  // alu_op[2:0] size/sign codes
  localparam logic [2:0] YSYX_LSU_B  = 3'b000;
  localparam logic [2:0] YSYX_LSU_H  = 3'b001;
  localparam logic [2:0] YSYX_LSU_W  = 3'b010;
  localparam logic [2:0] YSYX_LSU_BU = 3'b100;
  localparam logic [2:0] YSYX_LSU_HU = 3'b101;

  // unshifted byte-strobe masks per access size
  localparam logic [NUM_LANES-1:0] YSYX_LSU_STRB_B = 4'b0001;
  localparam logic [NUM_LANES-1:0] YSYX_LSU_STRB_H = 4'b0011;
  localparam logic [NUM_LANES-1:0] YSYX_LSU_STRB_W = 4'b1111;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // request captured in IDLE and held for the whole transaction
  typedef struct packed {
    logic                    is_load;
    logic [YSYX_W_WIDTH-1:0] addr;
    logic [2:0]              op;
    logic [YSYX_W_WIDTH-1:0] wdata;
  } lsu_req_t;

  // size class from op; unused encodings behave as a full word
  function automatic lsu_size_t lsu_size(input logic [2:0] op);
    case (op[1:0])
      2'b00:   lsu_size = SZ_B;
      2'b01:   lsu_size = SZ_H;
      default: lsu_size = SZ_W;
    endcase
  endfunction
endpackage

// File: rtl/ysyx_lsu_align.sv
// Combinational byte-lane logic: store shift and strobes, load shift and
// sign/zero extension, and misalignment detect.
module ysyx_lsu_align
  import ysyx_lsu_pkg::*;
#(
  parameter int BIT_W = YSYX_W_WIDTH
) (
  input  logic [1:0]           off,
  input  logic [2:0]           op,
  input  logic [BIT_W-1:0]     wdata,
  input  logic [BIT_W-1:0]     rword,
  output logic [BIT_W-1:0]     wdata_sh,
  output logic [NUM_LANES-1:0] wstrb,
  output logic [BIT_W-1:0]     rdata_ext,
  output logic                 misalign
);
  logic [4:0]       sh;
  logic [BIT_W-1:0] rsh;
  lsu_size_t        sz;

  assign sh       = {off, 3'b000};
  assign sz       = lsu_size(op);
  assign wdata_sh = wdata << sh;

  // strobe mask shifted into the addressed lanes; lanes past 3 drop off
  always_comb begin
    wstrb = '0;
    case (sz)
      SZ_B:    wstrb = YSYX_LSU_STRB_B << off;
      SZ_H:    wstrb = YSYX_LSU_STRB_H << off;
      default: wstrb = YSYX_LSU_STRB_W;
    endcase
  end

  // bring the addressed bytes down to bit 0, then extend by op
  always_comb begin
    rsh       = rword >> sh;
    rdata_ext = rsh;
    case (op)
      YSYX_LSU_B:  rdata_ext = {{(BIT_W-8){rsh[7]}}, rsh[7:0]};
      YSYX_LSU_H:  rdata_ext = {{(BIT_W-16){rsh[15]}}, rsh[15:0]};
      YSYX_LSU_BU: rdata_ext = {{(BIT_W-8){1'b0}}, rsh[7:0]};
      YSYX_LSU_HU: rdata_ext = {{(BIT_W-16){1'b0}}, rsh[15:0]};
      default:     rdata_ext = rsh;
    endcase
  end

  // halfword needs even address, word needs 4-byte alignment
  always_comb begin
    misalign = 1'b0;
    case (sz)
      SZ_H:    misalign = off[0];
      SZ_W:    misalign = (off != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
endmodule

// File: rtl/ysyx_lsu_ctrl.sv
// LSU controller: accepts one execute-stage load/store at a time, issues a
// single valid/ready bus transaction and returns a one-cycle response pulse.
// Optional: YSYX_LSU_ALIGN_CHECK_EN short-circuits misaligned H/W accesses
// straight to an error response without touching the bus.
module ysyx_lsu_ctrl
  import ysyx_lsu_pkg::*;
#(
  parameter int BIT_W = YSYX_W_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_avalid,
  input  logic             ren,
  input  logic             wen,
  input  logic [BIT_W-1:0] addr,
  input  logic [3:0]       alu_op,
  input  logic [BIT_W-1:0] wdata,
  output logic [BIT_W-1:0] lsu_rdata,
  output logic             lsu_exu_rvalid,
  output logic             lsu_exu_wready,
  output logic             lsu_err,
  output logic             bus_avalid,
  output logic             bus_wen,
  output logic [BIT_W-1:0] bus_addr,
  output logic [BIT_W-1:0] bus_wdata,
  output logic [3:0]       bus_wstrb,
  input  logic             bus_aready,
  input  logic             bus_rvalid,
  input  logic [BIT_W-1:0] bus_rdata,
  input  logic             bus_bvalid,
  input  logic             bus_err
);
  lsu_state_t       state_q, state_d;
  lsu_req_t         req_q;
  logic [BIT_W-1:0] rdata_q;
  logic             err_q;

  logic             accept, skip;
  logic [1:0]       al_off;
  logic [2:0]       al_op;
  logic [BIT_W-1:0] al_wdata;
  logic [3:0]       al_wstrb;
  logic [BIT_W-1:0] al_rdata;
  logic             misalign;
  logic             unused_op;

  assign unused_op = alu_op[3];
  assign accept    = lsu_avalid & (ren | wen);

  // in IDLE the aligner checks the incoming request; afterwards it works on
  // the latched one
  assign al_off = (state_q == IDLE) ? addr[1:0]   : req_q.addr[1:0];
  assign al_op  = (state_q == IDLE) ? alu_op[2:0] : req_q.op;

  ysyx_lsu_align #(.BIT_W(BIT_W)) u_align (
    .off       (al_off),
    .op        (al_op),
    .wdata     (req_q.wdata),
    .rword     (bus_rdata),
    .wdata_sh  (al_wdata),
    .wstrb     (al_wstrb),
    .rdata_ext (al_rdata),
    .misalign  (misalign)
  );

`ifdef YSYX_LSU_ALIGN_CHECK_EN
  assign skip = misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign skip = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // request latch, load data and error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          req_q <= '{is_load: ren, addr: addr, op: alu_op[2:0], wdata: wdata};
          err_q <= skip;
          if (skip && ren) rdata_q <= '0;
        end
        WAIT: begin
          if (req_q.is_load && bus_rvalid) begin
            rdata_q <= al_rdata;
            err_q   <= bus_err;
          end else if (!req_q.is_load && bus_bvalid) begin
            err_q   <= bus_err;
          end
        end
        default: ;
      endcase
    end
  end

  // next state and bus/response outputs
  always_comb begin
    state_d        = state_q;
    bus_avalid     = 1'b0;
    bus_wen        = 1'b0;
    bus_wdata      = '0;
    bus_wstrb      = '0;
    lsu_exu_rvalid = 1'b0;
    lsu_exu_wready = 1'b0;
    lsu_err        = 1'b0;
    bus_addr       = {req_q.addr[BIT_W-1:2], 2'b00};
    lsu_rdata      = rdata_q;
    case (state_q)
      IDLE: if (accept) state_d = skip ? DONE : REQ;
      REQ: begin
        bus_avalid = 1'b1;
        bus_wen    = ~req_q.is_load;
        if (!req_q.is_load) begin
          bus_wdata = al_wdata;
          bus_wstrb = al_wstrb;
        end
        if (bus_aready) state_d = WAIT;
      end
      WAIT: if (req_q.is_load ? bus_rvalid : bus_bvalid) state_d = DONE;
      DONE: begin
        lsu_exu_rvalid = req_q.is_load;
        lsu_exu_wready = ~req_q.is_load;
        lsu_err        = err_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
